// File: rtl/reg_display_scan.sv
// reg_display_scan: picks a register index (manual or auto-scroll), samples that
// register through a SEL/WAIT/LATCH loop and multiplexes its low 16 bits as four
// hex digits onto a common-anode 7-segment display (anodes and cathodes active-low).
//
// Handshake with the register file: none beyond timing. disp is registered in
// SEL, reg_val is allowed one full WAIT cycle to settle, and is captured in LATCH.
module reg_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int SCROLL_DIV  = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  sel,
    input  logic        auto_en,
    input  logic        hold,
    output logic [3:0]  disp,
    input  logic [15:0] reg_val,
    output logic [3:0]  idx_led,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int REF_W = $clog2(REFRESH_DIV);
    localparam int SCR_W = $clog2(SCROLL_DIV);

    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [SCR_W-1:0] SCR_LAST = SCR_W'(SCROLL_DIV - 1);

    typedef enum logic [1:0] {
        ST_SEL   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              disp_load;
    logic              latch_en;

    logic [3:0]        tgt;
    logic [SCR_W-1:0]  scroll_cnt;
    logic [REF_W-1:0]  refresh_cnt;
    logic [1:0]        digit;
    logic [15:0]       shown;
    logic [3:0]        nibble;
    logic [6:0]        seg_next;

    // Target index: follow sel in manual mode, step every SCROLL_DIV cycles in auto
    // mode; hold freezes both the index and the scroll counter (and wins over a
    // terminal count in the same cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            tgt        <= 4'd0;
            scroll_cnt <= '0;
        end else if (!auto_en) begin
            tgt        <= sel;
            scroll_cnt <= '0;
        end else if (!hold) begin
            if (scroll_cnt == SCR_LAST) begin
                scroll_cnt <= '0;
                tgt        <= tgt + 4'd1;
            end else begin
                scroll_cnt <= scroll_cnt + SCR_W'(1);
            end
        end
    end

    // Capture FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_SEL;
        end else begin
            state <= state_next;
        end
    end

    // Capture FSM next state and load strobes: a free-running SEL -> WAIT -> LATCH loop.
    always_comb begin
        state_next = state;
        disp_load  = 1'b0;
        latch_en   = 1'b0;
        case (state)
            ST_SEL: begin
                disp_load  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en   = !hold;
                state_next = ST_SEL;
            end
            default: begin
                state_next = ST_SEL;
            end
        endcase
    end

    // Capture datapath: drive the index out in SEL, latch value and index in LATCH.
    // idx_led takes disp (not tgt) so the index always matches the latched value.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp    <= 4'd0;
            shown   <= 16'd0;
            idx_led <= 4'd0;
        end else begin
            if (disp_load) begin
                disp <= tgt;
            end
            if (latch_en) begin
                shown   <= reg_val;
                idx_led <= disp;
            end
        end
    end

    // Refresh timer: advance to the next digit every REFRESH_DIV cycles, never paused.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit       <= 2'd0;
        end else if (refresh_cnt == REF_LAST) begin
            refresh_cnt <= '0;
            digit       <= digit + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + REF_W'(1);
        end
    end

    // Select the nibble of the shown value that belongs to the current digit.
    always_comb begin
        nibble = shown[{digit, 2'b00} +: 4];
    end

    // Hex to 7-segment decode, active-low, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg_next = 7'b1111111;
        case (nibble)
            4'h0: seg_next = 7'b1000000;
            4'h1: seg_next = 7'b1111001;
            4'h2: seg_next = 7'b0100100;
            4'h3: seg_next = 7'b0110000;
            4'h4: seg_next = 7'b0011001;
            4'h5: seg_next = 7'b0010010;
            4'h6: seg_next = 7'b0000010;
            4'h7: seg_next = 7'b1111000;
            4'h8: seg_next = 7'b0000000;
            4'h9: seg_next = 7'b0010000;
            4'hA: seg_next = 7'b0001000;
            4'hB: seg_next = 7'b0000011;
            4'hC: seg_next = 7'b1000110;
            4'hD: seg_next = 7'b0100001;
            4'hE: seg_next = 7'b0000110;
            4'hF: seg_next = 7'b0001110;
            default: seg_next = 7'b1111111;
        endcase
    end

    // Registered pin drivers; they trail digit/shown by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1110;
            seg <= 7'b1000000;
        end else begin
            an  <= ~(4'b0001 << digit);
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_reg_display_scan.sv
// Testbench for reg_display_scan with short dividers. A behavioural register file
// answers disp combinationally; expected values are queued when stimulus is driven
// and popped when the matching DUT output is sampled on the falling edge.
module tb_reg_display_scan;

    localparam int REFRESH_DIV = 4;
    localparam int SCROLL_DIV  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sel = 4'd0;
    logic        auto_en = 1'b0;
    logic        hold = 1'b0;
    logic [3:0]  disp;
    logic [15:0] reg_val;
    logic [3:0]  idx_led;
    logic [3:0]  an;
    logic [6:0]  seg;

    logic [15:0] regs [16];
    logic [15:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    reg_display_scan #(
        .REFRESH_DIV(REFRESH_DIV),
        .SCROLL_DIV (SCROLL_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .auto_en(auto_en),
        .hold   (hold),
        .disp   (disp),
        .reg_val(reg_val),
        .idx_led(idx_led),
        .an     (an),
        .seg    (seg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Register file read port model.
    assign reg_val = regs[disp];

    // Edges since the last sampled reset; cyc % 3 gives the capture phase.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] hex7_model(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [3:0] an_model(input int d);
        case (d)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_pop(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] e);
        push(e);
        check_pop(tag, obs);
    endtask

    // Wait (bounded) until the anodes show the wanted pattern.
    task automatic wait_an(input logic [3:0] want);
        int n;
        n = 0;
        while (an !== want && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("an_reach", {12'd0, an}, {12'd0, want});
    endtask

    // For n cycles, check that the lit digit shows the matching nibble of val.
    task automatic sweep_digits(input string tag, input logic [15:0] val, input int n);
        int  d;
        logic ok;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ok = 1'b1;
            case (an)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: begin d = 0; ok = 1'b0; end
            endcase
            check({tag, "_an_onecold"}, {15'd0, ok}, 16'd1);
            if (ok) check(tag, {9'd0, seg}, {9'd0, hex7_model(val[4*d +: 4])});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp"}, {12'd0, disp}, 16'd0);
        check({tag, "_idx"}, {12'd0, idx_led}, 16'd0);
        check({tag, "_an"}, {12'd0, an}, 16'h000E);
        check({tag, "_seg"}, {9'd0, seg}, 16'h0040);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 16'd0;

        // Reset and the anode rotation (4 cycles per digit, one-cycle output lag).
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("an_step", {12'd0, an}, {12'd0, an_model(((k - 1) / 4) % 4)});
            check("seg_zero", {9'd0, seg}, 16'h0040);
        end

        // Manual select of r5 = A5F1.
        regs[5] = 16'hA5F1;
        sel = 4'd5;
        push(16'd5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (idx_led == 4'd5) break;
        end
        check_pop("idx_sel5", {12'd0, idx_led});
        check("disp_sel5", {12'd0, disp}, 16'd5);
        wait_an(4'b1110);
        check("seg_d0_1", {9'd0, seg}, 16'h0079);
        wait_an(4'b1101);
        check("seg_d1_F", {9'd0, seg}, 16'h000E);
        wait_an(4'b1011);
        check("seg_d2_5", {9'd0, seg}, 16'h0012);
        wait_an(4'b0111);
        check("seg_d3_A", {9'd0, seg}, 16'h0008);

        // Auto scroll from 14: steps every 8 cycles, 15 wraps to 0.
        sel = 4'd14;
        repeat (8) @(negedge clk);
        check("disp_pre_auto", {12'd0, disp}, 16'd14);
        auto_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            repeat (k == 1 ? 8 : 2) @(negedge clk);
            check("disp_before_step", {12'd0, disp}, 16'((14 + k - 1) % 16));
            repeat (3) @(negedge clk);
            check("disp_after_step", {12'd0, disp}, 16'((14 + k) % 16));
            repeat (3) @(negedge clk);
            check("idx_after_step", {12'd0, idx_led}, 16'((14 + k) % 16));
        end

        // Freeze: hold with r3 rewritten underneath, then release.
        auto_en = 1'b0;
        sel = 4'd3;
        regs[3] = 16'h1234;
        regs[4] = 16'h8888;
        repeat (8) @(negedge clk);
        check("idx_r3", {12'd0, idx_led}, 16'd3);
        auto_en = 1'b1;
        hold = 1'b1;
        regs[3] = 16'h8888;
        repeat (20) @(negedge clk);
        check("hold_disp", {12'd0, disp}, 16'd3);
        check("hold_idx", {12'd0, idx_led}, 16'd3);
        sweep_digits("hold_seg", 16'h1234, 16);
        hold = 1'b0;
        repeat (3) @(negedge clk);
        check("release_idx", {12'd0, idx_led}, 16'd3);
        sweep_digits("release_seg", 16'h8888, 16);

        // Reset while in LATCH and scrolling at index 9.
        auto_en = 1'b0;
        sel = 4'd9;
        repeat (8) @(negedge clk);
        auto_en = 1'b1;
        repeat (3) @(negedge clk);
        while (cyc % 3 != 2) @(negedge clk);
        check("disp_at_9", {12'd0, disp}, 16'd9);
        rst = 1'b1;
        auto_en = 1'b0;
        sel = 4'd0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        auto_en = 1'b1;
        repeat (8) @(negedge clk);
        check("restart_disp0", {12'd0, disp}, 16'd0);
        repeat (3) @(negedge clk);
        check("restart_disp1", {12'd0, disp}, 16'd1);
        repeat (3) @(negedge clk);
        check("restart_idx1", {12'd0, idx_led}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
